// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges the fixed-latency pipe result with queued
// long-latency results, and tracks which destinations still have a long-latency write pending.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_wb_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_en,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1_index,
    input  logic [4:0]      rs2_index,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wb_en,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      W_rd_index
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic            wb_from_q;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness looks at the current occupancy only; a same-cycle pop gives no credit.
    assign lsu_ready = (count < CW'(DEPTH));
    assign push      = lsu_valid & lsu_ready;
    assign pop       = ~pipe_wb_valid & (count != '0);

    assign rs1_busy = busy[rs1_index];
    assign rs2_busy = busy[rs2_index];

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lsu_rd;
            q_data[wr_ptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en      <= 1'b0;
            wb_data    <= '0;
            W_rd_index <= '0;
            wb_from_q  <= 1'b0;
        end else if (pipe_wb_valid) begin
            wb_en      <= (pipe_rd != 5'd0);
            wb_data    <= pipe_data;
            W_rd_index <= pipe_rd;
            wb_from_q  <= 1'b0;
        end else if (pop) begin
            wb_en      <= (q_rd[rd_ptr] != 5'd0);
            wb_data    <= q_data[rd_ptr];
            W_rd_index <= q_rd[rd_ptr];
            wb_from_q  <= 1'b1;
        end else begin
            wb_en      <= 1'b0;
            wb_from_q  <= 1'b0;
        end
    end

    // A queued write retires its busy bit as the register file commits; a new issue to the same rd wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_en && wb_from_q) busy_nxt[W_rd_index] = 1'b0;
        if (issue_en && (issue_rd != 5'd0)) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_nxt;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model compared every cycle, directed literal
// checks for latency/ordering/reset corners, then a long randomized run.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_wb_valid;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            issue_en;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1_index;
    logic [4:0]      rs2_index;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wb_en;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      W_rd_index;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pipe_wb_valid(pipe_wb_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_en(wb_en), .wb_data(wb_data), .W_rd_index(W_rd_index)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    ent_t            me;
    bit              mbusy[32];
    logic            m_wb_en   = 1'b0;
    logic [4:0]      m_idx     = '0;
    logic [XLEN-1:0] m_data    = '0;
    bit              m_from_q  = 1'b0;
    bit              m_push    = 1'b0;
    bit              mp;
    int              n_tests   = 0;
    int              n_fail    = 0;
    bit              chk_on    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a write each edge goes to the pipe if valid, else to the oldest queued result.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_wb_en = 1'b0; m_idx = '0; m_data = '0; m_from_q = 1'b0; m_push = 1'b0;
        end else begin
            mp = lsu_valid && (mq.size() < DEPTH);
            if (m_wb_en && m_from_q) mbusy[m_idx] = 1'b0;
            if (issue_en && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
            if (pipe_wb_valid) begin
                m_wb_en = (pipe_rd != 0); m_idx = pipe_rd; m_data = pipe_data; m_from_q = 1'b0;
            end else if (mq.size() > 0) begin
                me = mq.pop_front();
                m_wb_en = (me.rd != 0); m_idx = me.rd; m_data = me.data; m_from_q = 1'b1;
            end else begin
                m_wb_en = 1'b0; m_from_q = 1'b0;
            end
            if (mp) mq.push_back('{rd: lsu_rd, data: lsu_data});
            m_push = mp;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("wb_en",      {31'd0, wb_en},     {31'd0, m_wb_en});
            check("W_rd_index", {27'd0, W_rd_index}, {27'd0, m_idx});
            check("wb_data",    wb_data,            m_data);
            check("lsu_ready",  {31'd0, lsu_ready}, {31'd0, (mq.size() < DEPTH)});
            check("rs1_busy",   {31'd0, rs1_busy},  {31'd0, mbusy[rs1_index]});
            check("rs2_busy",   {31'd0, rs2_busy},  {31'd0, mbusy[rs2_index]});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        pipe_wb_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_en = 1'b0; issue_rd = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs1_index = '0; rs2_index = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_wb_en", {31'd0, wb_en}, 32'd0);
        check("reset_data", wb_data, 32'd0);
        check("reset_ready", {31'd0, lsu_ready}, 32'd1);

        // pipe write, then pipe write to x0
        step(); pipe_wb_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hDEADBEEF;
        step(); pipe_rd = 5'd0; pipe_data = 32'h55;
        @(negedge clk);
        check("pipe_en", {31'd0, wb_en}, 32'd1);
        check("pipe_idx", {27'd0, W_rd_index}, 32'd3);
        check("pipe_data", wb_data, 32'hDEADBEEF);
        step(); idle();
        @(negedge clk);
        check("pipe_x0_en", {31'd0, wb_en}, 32'd0);

        // long-latency path
        step(); issue_en = 1'b1; issue_rd = 5'd7;
        step(); issue_en = 1'b0; rs1_index = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h12345678;
        @(negedge clk);
        check("ll_busy_set", {31'd0, rs1_busy}, 32'd1);
        step(); lsu_valid = 1'b0;
        step();
        @(negedge clk);
        check("ll_en", {31'd0, wb_en}, 32'd1);
        check("ll_idx", {27'd0, W_rd_index}, 32'd7);
        check("ll_data", wb_data, 32'h12345678);
        check("ll_busy_hold", {31'd0, rs1_busy}, 32'd1);
        step();
        @(negedge clk);
        check("ll_busy_clr", {31'd0, rs1_busy}, 32'd0);

        // same-edge set/clear of rd=9
        step(); lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step(); lsu_valid = 1'b0;
        step(); issue_en = 1'b1; issue_rd = 5'd9; rs1_index = 5'd9;
        @(negedge clk);
        check("se_wb_idx", {27'd0, W_rd_index}, 32'd9);
        step(); issue_en = 1'b0;
        @(negedge clk);
        check("se_busy", {31'd0, rs1_busy}, 32'd1);

        // contention: pipe 4 cycles, three offers
        step(); pipe_wb_valid = 1'b1; pipe_rd = 5'd10; pipe_data = 32'hA0;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h200;
        step(); pipe_rd = 5'd11; pipe_data = 32'hA1; lsu_rd = 5'd21; lsu_data = 32'h201;
        step(); pipe_rd = 5'd12; pipe_data = 32'hA2; lsu_rd = 5'd22; lsu_data = 32'h202;
        @(negedge clk);
        check("ct_ready_full", {31'd0, lsu_ready}, 32'd0);
        step(); pipe_rd = 5'd13; pipe_data = 32'hA3;
        @(negedge clk);
        check("ct_pipe_idx", {27'd0, W_rd_index}, 32'd12);
        step(); pipe_wb_valid = 1'b0;
        @(negedge clk);
        check("ct_ready_c4", {31'd0, lsu_ready}, 32'd0);
        check("ct_last_pipe", {27'd0, W_rd_index}, 32'd13);
        step();
        @(negedge clk);
        check("ct_ready_c5", {31'd0, lsu_ready}, 32'd1);
        check("ct_q0_idx", {27'd0, W_rd_index}, 32'd20);
        step(); lsu_valid = 1'b0;
        @(negedge clk);
        check("ct_q1_idx", {27'd0, W_rd_index}, 32'd21);
        step();
        @(negedge clk);
        check("ct_q2_idx", {27'd0, W_rd_index}, 32'd22);
        check("ct_q2_data", wb_data, 32'h202);
        step(); idle();

        // wrap-around: six back-to-back results
        for (int k = 0; k < 8; k++) begin
            step();
            if (k < 6) begin
                lsu_valid = 1'b1; lsu_rd = 5'(k + 1); lsu_data = 32'((k + 1) * 16);
            end else begin
                lsu_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 2) begin
                check("wrap_en", {31'd0, wb_en}, 32'd1);
                check("wrap_idx", {27'd0, W_rd_index}, 32'(k - 1));
                check("wrap_data", wb_data, 32'((k - 1) * 16));
            end
        end

        // reset mid-stream with two queued entries and busy[5]
        step(); issue_en = 1'b1; issue_rd = 5'd5;
        pipe_wb_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd30; lsu_data = 32'h300;
        step(); issue_en = 1'b0; lsu_rd = 5'd31; lsu_data = 32'h301;
        step(); lsu_valid = 1'b0; rs1_index = 5'd5;
        @(negedge clk);
        check("rst_pre_busy", {31'd0, rs1_busy}, 32'd1);
        check("rst_pre_full", {31'd0, lsu_ready}, 32'd0);
        #2 rst = 1'b0; pipe_wb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_ready", {31'd0, lsu_ready}, 32'd1);
        check("rst_busy", {31'd0, rs1_busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("rst_no_stale", {31'd0, wb_en}, 32'd0);
        end

        // randomized traffic; second half leans on the pipe to starve the queue
        for (int c = 0; c < 3000; c++) begin
            step();
            pipe_wb_valid = ($urandom_range(0, 99) < ((c < 1500) ? 30 : 75));
            pipe_rd = 5'($urandom_range(0, 31));
            pipe_data = $urandom;
            if (!(lsu_valid && !m_push)) begin
                lsu_valid = ($urandom_range(0, 1) == 1);
                lsu_rd = 5'($urandom_range(0, 31));
                lsu_data = $urandom;
            end
            issue_en = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 31));
            rs1_index = 5'($urandom_range(0, 31));
            rs2_index = 5'($urandom_range(0, 31));
        end
        step(); idle();
        repeat (4) step();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
